camara_emulador: RTL and testbench



---
 rtl/camara_emulador.sv | 176 +++++++++++++++++
 tb/tb_camara_emulador.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/camara_emulador.sv
// OV7670-style camera source: vsync/href/data RGB565 byte stream with test patterns.
// Frame timing is counted from VSYNC entry; every output is a registered copy of next-state values.
module camara_emulador #(
    parameter int H_PIXELS    = 160,
    parameter int V_LINES     = 120,
    parameter int H_BLANK     = 16,
    parameter int VSYNC_LINES = 3,
    parameter int VBP_LINES   = 2,
    parameter int VFP_LINES   = 2,
    parameter int BAR_SHIFT   = 4
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_rgb,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  data,
    output logic        frame_done,
    output logic        busy
);

    localparam int LINE_CYCLES = 2 * H_PIXELS + H_BLANK;
    localparam int ACT_CYC     = 2 * H_PIXELS;
    localparam int VS_CYC      = VSYNC_LINES * LINE_CYCLES;
    localparam int VBP_CYC     = VBP_LINES * LINE_CYCLES;
    localparam int VFP_CYC     = VFP_LINES * LINE_CYCLES;
    localparam int MAX_L01     = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
    localparam int MAX_L       = (MAX_L01 > VFP_LINES) ? MAX_L01 : VFP_LINES;
    localparam int CW          = $clog2(MAX_L * LINE_CYCLES);
    localparam int XW          = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int YW          = (V_LINES > 1) ? $clog2(V_LINES) : 1;

    localparam logic [CW-1:0] VS_LAST  = CW'(VS_CYC - 1);
    localparam logic [CW-1:0] VBP_LAST = CW'(VBP_CYC - 1);
    localparam logic [CW-1:0] ACT_LAST = CW'(ACT_CYC - 1);
    localparam logic [CW-1:0] HB_LAST  = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] VFP_LAST = CW'(VFP_CYC - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_LINES - 1);

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBP,
        ACTIVE,
        HBLANK,
        VFP
    } state_t;

    state_t      state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [YW-1:0] y, y_nx;
    logic [15:0] pixcnt, pixcnt_nx;
    logic [4:0]  fcnt, fcnt_nx;
    logic [1:0]  sel, sel_nx;
    logic [15:0] solid, solid_nx;
    logic        latch;
    logic [XW-1:0] x_nx;
    logic [2:0]  bar;
    logic [15:0] pix;
    logic [7:0]  byte_nx;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt + 1'b1;
        y_nx      = y;
        pixcnt_nx = pixcnt;
        fcnt_nx   = fcnt;
        latch     = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (enable) begin
                    state_nx = VSYNC;
                    latch    = 1'b1;
                end
            end
            VSYNC: begin
                if (cnt == VS_LAST) begin
                    state_nx = VBP;
                    cnt_nx   = '0;
                end
            end
            VBP: begin
                if (cnt == VBP_LAST) begin
                    state_nx = ACTIVE;
                    cnt_nx   = '0;
                    y_nx     = '0;
                end
            end
            ACTIVE: begin
                if (cnt[0]) pixcnt_nx = pixcnt + 16'd1;
                if (cnt == ACT_LAST) begin
                    state_nx = HBLANK;
                    cnt_nx   = '0;
                end
            end
            HBLANK: begin
                if (cnt == HB_LAST) begin
                    cnt_nx = '0;
                    if (y != Y_LAST) begin
                        y_nx     = y + 1'b1;
                        state_nx = ACTIVE;
                    end else begin
                        state_nx = VFP;
                    end
                end
            end
            VFP: begin
                if (cnt == VFP_LAST) begin
                    cnt_nx  = '0;
                    fcnt_nx = fcnt + 5'd1;
                    if (enable) begin
                        state_nx = VSYNC;
                        latch    = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
        sel_nx   = latch ? pattern_sel : sel;
        solid_nx = latch ? solid_rgb : solid;
        if (latch) pixcnt_nx = '0;
    end

    // Pixel for the byte that will be on the bus after this edge
    always_comb begin
        x_nx = cnt_nx[XW:1];
        bar  = 3'(16'(x_nx) >> BAR_SHIFT);
        pix  = '0;
        unique case (sel_nx)
            2'd0: pix = {{5{bar[2]}}, {6{bar[1]}}, {5{bar[0]}}};
            2'd1: pix = {5'(x_nx), 6'(y_nx), fcnt};
            2'd2: pix = solid_nx;
            default: pix = pixcnt_nx;
        endcase
        byte_nx = cnt_nx[0] ? pix[7:0] : pix[15:8];
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            y          <= '0;
            pixcnt     <= '0;
            fcnt       <= '0;
            sel        <= '0;
            solid      <= '0;
            vsync      <= 1'b0;
            href       <= 1'b0;
            data       <= 8'h00;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            y          <= y_nx;
            pixcnt     <= pixcnt_nx;
            fcnt       <= fcnt_nx;
            sel        <= sel_nx;
            solid      <= solid_nx;
            vsync      <= (state_nx == VSYNC);
            href       <= (state_nx == ACTIVE);
            data       <= (state_nx == ACTIVE) ? byte_nx : 8'h00;
            frame_done <= (state_nx == VFP) && (cnt_nx == VFP_LAST);
            busy       <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_camara_emulador.sv
// Bench for camara_emulador: frame-position reference model plus directed literal checks.
module tb_camara_emulador;

    localparam int HP   = 4;
    localparam int VL   = 2;
    localparam int HB   = 2;
    localparam int VSL  = 1;
    localparam int VBPL = 1;
    localparam int VFPL = 1;
    localparam int BS   = 1;
    localparam int LC   = 2 * HP + HB;
    localparam int FR   = (VSL + VBPL + VL + VFPL) * LC;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd3;
    logic [15:0] solid_rgb = 16'h0000;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        frame_done;
    logic        busy;

    int total = 0;
    int bad = 0;

    bit m_run = 1'b0;
    int m_t = 0;
    int m_fc = 0;
    int m_sel = 0;
    int m_solid = 0;

    int capq[$];
    int fd_q[$];
    int vs_cnt = 0;
    int vs_fall = -1;
    int href_rise = -1;
    int cyc = 0;
    int fd_total = 0;
    bit prev_vs = 1'b0;
    bit prev_hr = 1'b0;

    always #5 pclk = ~pclk;

    camara_emulador #(
        .H_PIXELS(HP),
        .V_LINES(VL),
        .H_BLANK(HB),
        .VSYNC_LINES(VSL),
        .VBP_LINES(VBPL),
        .VFP_LINES(VFPL),
        .BAR_SHIFT(BS)
    ) dut (
        .pclk(pclk),
        .rst(rst),
        .enable(enable),
        .pattern_sel(pattern_sel),
        .solid_rgb(solid_rgb),
        .vsync(vsync),
        .href(href),
        .data(data),
        .frame_done(frame_done),
        .busy(busy)
    );

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic int model_pix(input int x, input int y);
        int b;
        case (m_sel)
            0: begin
                b = (x >> BS) & 7;
                return (((b & 4) != 0 ? 31 : 0) << 11) |
                       (((b & 2) != 0 ? 63 : 0) << 5) |
                       ((b & 1) != 0 ? 31 : 0);
            end
            1: return ((x & 31) << 11) | ((y & 63) << 5) | (m_fc & 31);
            2: return m_solid;
            default: return (y * HP + x) & 16'hffff;
        endcase
    endfunction

    // Reference: outputs follow from position within the frame
    always @(posedge pclk) begin
        int line, col, al, pix;
        int e_vs, e_hr, e_d, e_fd, e_bz;
        if (rst) begin
            m_run = 1'b0;
            m_t = 0;
            m_fc = 0;
        end else if (!m_run) begin
            if (enable) begin
                m_run = 1'b1;
                m_t = 0;
                m_sel = int'(pattern_sel);
                m_solid = int'(solid_rgb);
            end
        end else if (m_t == FR - 1) begin
            m_fc = (m_fc + 1) & 16'hffff;
            if (enable) begin
                m_t = 0;
                m_sel = int'(pattern_sel);
                m_solid = int'(solid_rgb);
            end else begin
                m_run = 1'b0;
            end
        end else begin
            m_t++;
        end
        #1;
        e_vs = 0; e_hr = 0; e_d = 0; e_fd = 0; e_bz = 0;
        if (m_run) begin
            line = m_t / LC;
            col = m_t % LC;
            al = line - VSL - VBPL;
            e_vs = (line < VSL) ? 1 : 0;
            e_bz = 1;
            e_fd = (m_t == FR - 1) ? 1 : 0;
            if (al >= 0 && al < VL && col < 2 * HP) begin
                e_hr = 1;
                pix = model_pix(col / 2, al);
                e_d = (col % 2 == 1) ? (pix & 255) : ((pix >> 8) & 255);
            end
        end
        chk("vsync", int'(vsync), e_vs);
        chk("href", int'(href), e_hr);
        chk("data", int'(data), e_d);
        chk("frame_done", int'(frame_done), e_fd);
        chk("busy", int'(busy), e_bz);
        if (href) capq.push_back(int'(data));
        if (vsync) vs_cnt++;
        if (prev_vs && !vsync && vs_fall < 0) vs_fall = cyc;
        if (href && !prev_hr && href_rise < 0) href_rise = cyc;
        if (frame_done) begin
            fd_q.push_back(cyc);
            fd_total++;
        end
        prev_vs = vsync;
        prev_hr = href;
        cyc++;
    end

    task automatic clr();
        capq.delete();
        vs_cnt = 0;
        vs_fall = -1;
        href_rise = -1;
    endtask

    task automatic wait_fd(input int lim);
        int n0 = fd_total;
        int i = 0;
        while (fd_total == n0 && i < lim) begin
            @(negedge pclk);
            i++;
        end
        chk("fd_seen", (fd_total != n0) ? 1 : 0, 1);
    endtask

    task automatic chk_period(input string name);
        if (fd_q.size() >= 2) chk(name, fd_q[$] - fd_q[$-1], FR);
        else chk(name, fd_q.size(), 2);
    endtask

    task automatic chk_pair(input string name, input int hi, input int lo);
        chk({name, "_len"}, capq.size(), 2 * HP * VL);
        foreach (capq[i]) chk(name, capq[i], (i % 2 == 0) ? hi : lo);
    endtask

    initial begin
        int exp_cnt[16] = '{0, 0, 0, 1, 0, 2, 0, 3, 0, 4, 0, 5, 0, 6, 0, 7};
        int exp_bar[8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h1F};
        int n;
        int i;

        repeat (3) @(negedge pclk);
        rst = 1'b0;
        repeat (100) @(negedge pclk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_fd_count", fd_total, 0);

        pattern_sel = 2'd3;
        clr();
        enable = 1'b1;
        wait_fd(200);
        chk("cnt_len", capq.size(), 16);
        for (int k = 0; k < 16; k++)
            if (k < capq.size()) chk("cnt_byte", capq[k], exp_cnt[k]);
        chk("vs_cycles", vs_cnt, LC * VSL);
        chk("href_delay", href_rise - vs_fall, LC * VBPL);

        pattern_sel = 2'd2;
        solid_rgb = 16'hF800;
        clr();
        repeat (25) @(negedge pclk);
        solid_rgb = 16'h07E0;
        wait_fd(200);
        chk_pair("solid_f800", 8'hF8, 8'h00);
        chk_period("fd_period_a");

        clr();
        wait_fd(200);
        chk_pair("solid_07e0", 8'h07, 8'hE0);
        chk_period("fd_period_b");

        pattern_sel = 2'd0;
        clr();
        wait_fd(200);
        chk("bar_len", capq.size(), 16);
        for (int k = 0; k < 8; k++)
            if (k < capq.size()) chk("bar_byte", capq[k], exp_bar[k]);
        chk_period("fd_period_c");

        pattern_sel = 2'd1;
        clr();
        n = fd_total;
        repeat (20) @(negedge pclk);
        enable = 1'b0;
        wait_fd(200);
        repeat (60) @(negedge pclk);
        chk("drop_fd_count", fd_total - n, 1);
        chk("drop_len", capq.size(), 16);
        chk("drop_busy", int'(busy), 0);

        pattern_sel = 2'd3;
        clr();
        enable = 1'b1;
        i = 0;
        while (capq.size() < 12 && i < 300) begin
            @(negedge pclk);
            i++;
        end
        chk("rst_reach", capq.size(), 12);
        if (capq.size() >= 12) chk("rst_byte", capq[11], 5);
        rst = 1'b1;
        @(negedge pclk);
        chk("rst_vsync", int'(vsync), 0);
        chk("rst_href", int'(href), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_fd", int'(frame_done), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        enable = 1'b0;
        @(negedge pclk);

        for (int it = 0; it < 40; it++) begin
            pattern_sel = 2'($urandom_range(0, 3));
            solid_rgb = 16'($urandom);
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge pclk);
                rst = 1'b0;
            end
            repeat ($urandom_range(5, 150)) @(negedge pclk);
        end
        enable = 1'b0;
        repeat (60) @(negedge pclk);
        chk("final_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
